// File: rtl/fpadd_pkg.sv
// Shared types and constants for the fpadd request scheduler.
package fpadd_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int TIMEOUT_DEF = 512;

    // Returned in place of a sum when the adder never answers.
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_WIN = 3'd1,
        SEND_A   = 3'd2,
        SEND_B   = 3'd3,
        WAIT_SUM = 3'd4,
        RESP     = 3'd5
    } state_e;

    // Subtraction is done by the adder itself once the sign of B is flipped.
    function automatic logic [31:0] apply_sub(input logic [31:0] b, input logic sub);
        return {b[31] ^ sub, b[30:0]};
    endfunction

endpackage

// File: rtl/fpadd_sched_rr_arbiter.sv
// Round-robin picker: the search starts one past ptr_i and wraps modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    // First requester at or after ptr_i+1 wins; later hits are masked.
    always_comb begin
        int  j;
        logic hit;
        logic take;
        grant_o = '0;
        idx_o   = '0;
        hit     = 1'b0;
        j       = 0;
        take    = 1'b0;
        for (int off = 1; off <= N; off++) begin
            j          = (int'(ptr_i) + off) % N;
            take       = req_i[j] && !hit;
            grant_o[j] = take;
            idx_o      = take ? IW'(j) : idx_o;
            hit        = hit | take;
        end
    end

endmodule

// File: rtl/fpadd_sched.sv
// Shares one free-running serial fpadder between NUM_REQ requesters, one
// operation at a time, with a timeout that reports a canonical NaN.
module fpadd_sched
    import fpadd_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    parameter int  TIMEOUT = TIMEOUT_DEF,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][31:0] req_a,
    input  logic [NUM_REQ-1:0][31:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [31:0]              rsp_sum,
    output logic                     rsp_err,
    output logic [31:0]              fp_a,
    input  logic                     fp_ready,
    input  logic [31:0]              fp_sum,
    output logic                     busy
);

    localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic               fp_ready_q;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [31:0]        rsp_sum_q, rsp_sum_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        fp_a_q, fp_a_d;
    logic               rsp_valid_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] grant_s;
    logic [IDW-1:0]     gidx_s;
    logic               rise_s;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .idx_o   (gidx_s)
    );

    // fp_ready_q resets high so a window already open at reset release is not a rise.
    assign rise_s = fp_ready && !fp_ready_q;

    // Next-state and datapath-load decisions for the single outstanding operation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        rsp_sum_d = rsp_sum_q;
        rsp_err_d = rsp_err_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (|grant_s) begin
                    req_ready = grant_s;
                    ptr_d     = gidx_s;
                    id_d      = gidx_s;
                    a_d       = req_a[gidx_s];
                    b_d       = apply_sub(req_b[gidx_s], req_sub[gidx_s]);
                    state_d   = WAIT_WIN;
                end else begin
                    state_d   = IDLE;
                end
            end
            WAIT_WIN: begin
                if (rise_s) begin
                    state_d = SEND_A;
                end else begin
                    state_d = WAIT_WIN;
                end
            end
            SEND_A: begin
                state_d = SEND_B;
            end
            SEND_B: begin
                cnt_d   = '0;
                state_d = WAIT_SUM;
            end
            WAIT_SUM: begin
                if (rise_s) begin
                    rsp_sum_d = fp_sum;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_sum_d = CANON_NAN;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    state_d   = WAIT_SUM;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand bus is keyed off the next state so fp_a lines up with the adder's load cycles.
    always_comb begin
        fp_a_d = 32'h0;
        case (state_d)
            SEND_A:  fp_a_d = a_q;
            SEND_B:  fp_a_d = b_q;
            default: fp_a_d = 32'h0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fp_ready_q  <= 1'b1;
            ptr_q       <= PTR_RST;
            id_q        <= '0;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            cnt_q       <= '0;
            rsp_sum_q   <= 32'h0;
            rsp_err_q   <= 1'b0;
            fp_a_q      <= 32'h0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fp_ready_q  <= fp_ready;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_err_q   <= rsp_err_d;
            fp_a_q      <= fp_a_d;
            rsp_valid_q <= (state_d == RESP);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_err   = rsp_err_q;
    assign fp_a      = fp_a_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fpadd_sched.sv
// Scoreboard bench for fpadd_sched with a behavioural serial-adder model.
module tb_fpadd_sched;

    localparam int NR     = 4;
    localparam int TO     = 512;
    localparam int PERIOD = 8;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_ready;
    logic [NR-1:0][31:0] req_a;
    logic [NR-1:0][31:0] req_b;
    logic [NR-1:0]       req_sub;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_id;
    logic [31:0]         rsp_sum;
    logic                rsp_err;
    logic [31:0]         fp_a;
    logic                fp_ready;
    logic [31:0]         fp_sum = 32'h0;
    logic                busy;

    always #5 clock = ~clock;

    fpadd_sched #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .fp_a      (fp_a),
        .fp_ready  (fp_ready),
        .fp_sum    (fp_sum),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {int id; logic [31:0] sum; logic err;} rsp_t;
    typedef struct {logic [31:0] a; logic [31:0] b;} op_t;
    rsp_t sb_q[$];
    op_t  op_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- adder model (free-running, not reset by the DUT reset)
    function automatic real s2r(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:0] == 31'h0) return 0.0;
        d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return 32'h0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
        return r2s(s2r(a) + s2r(b));
    endfunction

    int          ph       = 0;
    logic        hang     = 1'b0;
    logic        hang_arm = 1'b0;
    logic [31:0] a_cap    = 32'h0;
    logic [31:0] res_q    = 32'h0;
    logic        ld_pulse = 1'b0;
    logic [31:0] ld_a     = 32'h0;
    logic [31:0] ld_b     = 32'h0;
    int          b_loads  = 0;

    assign fp_ready = !hang && (ph < 2);

    always @(posedge clock) begin
        ld_pulse <= 1'b0;
        if (hang) begin
            if (!hang_arm) hang <= 1'b0;
        end else begin
            ph <= (ph == PERIOD - 1) ? 0 : ph + 1;
            if (ph == 1) a_cap <= fp_a;
            if (ph == 2) begin
                res_q  <= f_add(a_cap, fp_a);
                fp_sum <= 32'hDEAD_BEEF;
                if (a_cap != 32'h0 || fp_a != 32'h0) begin
                    ld_pulse <= 1'b1;
                    ld_a     <= a_cap;
                    ld_b     <= fp_a;
                    b_loads  <= b_loads + 1;
                    if (hang_arm) hang <= 1'b1;
                end
            end
            if (ph == PERIOD - 1) fp_sum <= res_q;
        end
    end

    // ---------------- monitor: protocol, operand loads, responses, stall stability
    logic        stall_prev = 1'b0;
    int          sv_id      = 0;
    logic [31:0] sv_sum     = 32'h0;
    logic        sv_err     = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (fp_a != 32'h0)
                chk("fp_a_outside_load", 32'(((ph == 1) || (ph == 2)) && !hang), 32'd1);
            if (ld_pulse) begin
                chk("load_expected", 32'(op_q.size() > 0), 32'd1);
                if (op_q.size() > 0) begin
                    op_t o;
                    o = op_q.pop_front();
                    chk("load_a", ld_a, o.a);
                    chk("load_b", ld_b, o.b);
                end
            end
            if (rsp_valid && stall_prev) begin
                chk("stall_id",  32'(rsp_id), 32'(sv_id));
                chk("stall_sum", rsp_sum, sv_sum);
                chk("stall_err", 32'(rsp_err), 32'(sv_err));
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    rsp_t e;
                    e = sb_q.pop_front();
                    chk("rsp_id",  32'(rsp_id), 32'(e.id));
                    chk("rsp_sum", rsp_sum, e.sum);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            stall_prev = rsp_valid && !rsp_ready;
            sv_id      = int'(rsp_id);
            sv_sum     = rsp_sum;
            sv_err     = rsp_err;
        end
    end

    // ---------------- stimulus helpers
    task automatic push_exp(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic [31:0] s, input logic e);
        rsp_t r;
        op_t  o;
        r.id = id; r.sum = s; r.err = e;
        o.a = a; o.b = {b[31] ^ sub, b[30:0]};
        sb_q.push_back(r);
        op_q.push_back(o);
    endtask

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] s, input logic e, input int align);
        bit got;
        got = 1'b0;
        if (align >= 0) begin
            for (int n = 0; n < 100; n++) begin
                @(negedge clock);
                if (!hang && ph == (align + PERIOD - 1) % PERIOD) break;
            end
        end
        @(posedge clock); #1;
        req_valid[id] = 1'b1; req_a[id] = a; req_b[id] = b; req_sub[id] = sub;
        for (int n = 0; n < 2000 && !got; n++) begin
            @(negedge clock);
            if (req_ready[id]) begin
                got = 1'b1;
                if (align >= 0) chk("grant_phase", 32'(ph), 32'(align));
                push_exp(id, a, b, sub, s, e);
            end
        end
        chk("grant_seen", 32'(got), 32'd1);
        @(posedge clock); #1;
        req_valid[id] = 1'b0; req_a[id] = 32'hFFFF_FFFF; req_b[id] = 32'hFFFF_FFFF; req_sub[id] = ~sub;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            if (sb_q.size() == 0 && !rsp_valid) break;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_load(input int bl);
        for (int n = 0; n < 500; n++) begin
            if (b_loads != bl) break;
            @(negedge clock);
        end
        chk("load_seen", 32'(b_loads != bl), 32'd1);
    endtask

    task automatic chk_zero_outputs();
        chk("z_req_ready", 32'(req_ready), 32'd0);
        chk("z_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("z_rsp_id",    32'(rsp_id),    32'd0);
        chk("z_rsp_sum",   rsp_sum,        32'd0);
        chk("z_rsp_err",   32'(rsp_err),   32'd0);
        chk("z_fp_a",      fp_a,           32'd0);
        chk("z_busy",      32'(busy),      32'd0);
    endtask

    logic [31:0] ta [NR];
    logic [31:0] tb [NR];
    logic        ts [NR];
    logic [31:0] tx [NR];

    initial begin
        int got4;
        int gi;
        int bl;
        int cyc;
        req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b1;
        ta[0] = 32'h3F80_0000; tb[0] = 32'h3F80_0000; ts[0] = 1'b0; tx[0] = 32'h4000_0000;
        ta[1] = 32'h4000_0000; tb[1] = 32'h4000_0000; ts[1] = 1'b0; tx[1] = 32'h4080_0000;
        ta[2] = 32'h4080_0000; tb[2] = 32'h3F80_0000; ts[2] = 1'b1; tx[2] = 32'h4040_0000;
        ta[3] = 32'h3F00_0000; tb[3] = 32'h3E80_0000; ts[3] = 1'b0; tx[3] = 32'h3F40_0000;

        repeat (3) @(negedge clock);
        chk_zero_outputs();
        @(posedge clock); #1 reset = 1'b0;

        // all four requesters at once, held until granted
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = 1'b1; req_a[i] = ta[i]; req_b[i] = tb[i]; req_sub[i] = ts[i];
        end
        got4 = 0;
        for (int n = 0; n < 4000 && got4 < NR; n++) begin
            @(negedge clock);
            if (|req_ready) begin
                gi = 0;
                for (int i = NR - 1; i >= 0; i--) if (req_ready[i]) gi = i;
                chk("rr_order", 32'(gi), 32'(got4));
                push_exp(gi, ta[gi], tb[gi], ts[gi], tx[gi], 1'b0);
                got4++;
                @(posedge clock); #1 req_valid[gi] = 1'b0;
            end
        end
        chk("rr_all_granted", 32'(got4), 32'(NR));
        wait_done();

        issue(2, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, -1);
        wait_done();
        issue(0, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0, -1);
        wait_done();
        // grants landing inside an open window must wait for the next rise
        issue(1, 32'h40A0_0000, 32'h4040_0000, 1'b0, 32'h4100_0000, 1'b0, 0);
        wait_done();
        issue(2, 32'h40E0_0000, 32'h3F80_0000, 1'b1, 32'h40C0_0000, 1'b0, 1);
        wait_done();

        // adder goes silent after loading operands
        hang_arm = 1'b1;
        bl = b_loads;
        issue(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b1, -1);
        wait_load(bl);
        cyc = 0;
        while (!rsp_valid && cyc < 5000) begin
            cyc++;
            @(negedge clock);
        end
        chk("timeout_cycles", 32'(cyc), 32'(TO));
        wait_done();
        hang_arm = 1'b0;

        // stalled response must hold steady
        rsp_ready = 1'b0;
        issue(3, 32'h4120_0000, 32'h40A0_0000, 1'b1, 32'h40A0_0000, 1'b0, -1);
        for (int n = 0; n < 500 && !rsp_valid; n++) @(negedge clock);
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (20) @(negedge clock);
        @(posedge clock); #1 rsp_ready = 1'b1;
        wait_done();

        // reset while waiting for the sum abandons the operation
        bl = b_loads;
        issue(2, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, -1);
        wait_load(bl);
        @(posedge clock); #1 reset = 1'b1;
        sb_q.delete();
        op_q.delete();
        @(negedge clock);
        chk_zero_outputs();
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk_zero_outputs();
        issue(1, 32'h4040_0000, 32'h4040_0000, 1'b0, 32'h40C0_0000, 1'b0, -1);
        wait_done();

        chk("ops_left", 32'(op_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fpadd_sched.md
FPADD_SCHED -- requirements
Module: fpadd_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one fpadder; ID width IDW = $clog2(NUM_REQ).
REQ-002 SHALL have parameter TIMEOUT, default 512: maximum cycles waited for an adder result.
REQ-003 SHALL have ports:
  clock  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-high reset.
  req_valid  in  NUM_REQ  per-requester operation request.
  req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
  req_a  in  NUM_REQ x 32  operand A, IEEE-754 single.
  req_b  in  NUM_REQ x 32  operand B, IEEE-754 single.
  req_sub  in  NUM_REQ  1 = compute A-B, 0 = A+B.
  rsp_valid  out  1  result available.
  rsp_ready  in  1  result consumed.
  rsp_id  out  IDW  index of the requester that owns the result.
  rsp_sum  out  32  result word.
  rsp_err  out  1  1 = adder timed out.
  fp_a  out  32  drives the adder's serial operand port.
  fp_ready  in  1  adder ready flag.
  fp_sum  in  32  adder sum register.
  busy  out  1  high in every state except IDLE.

Function
REQ-004 Adder protocol: fp_ready is high for exactly two cycles (W1, W2). The adder samples operand A at the end of W2 and operand B at the end of the following cycle. fp_sum is valid from the next fp_ready rising edge.
REQ-005 The adder free-runs. fp_a SHALL be 32'h0 in every state except SEND_A and SEND_B, so idle windows compute 0+0 and their results are discarded.
REQ-006 FSM states SHALL be IDLE, WAIT_WIN, SEND_A, SEND_B, WAIT_SUM and RESP.
REQ-007 IDLE: if any req_valid is set, grant one requester by round-robin, starting from the index after the last grant. Assert req_ready for that requester for one cycle. Latch req_a, req_b^{req_sub,31'b0} and the grant ID. Go to WAIT_WIN.
REQ-008 WAIT_WIN: a rise is fp_ready==1 && fp_ready_q==0, where fp_ready_q is fp_ready registered. On a rise go to SEND_A. Entering mid-window SHALL NOT count; wait for the next rise.
REQ-009 SEND_A: fp_a = latched A; go to SEND_B unconditionally.
REQ-010 SEND_B: fp_a = latched B; clear the timeout counter; go to WAIT_SUM.
REQ-011 WAIT_SUM: on a fp_ready rise, capture fp_sum into rsp_sum, set rsp_err=0, go to RESP. Otherwise increment the counter; when it reaches TIMEOUT-1, set rsp_sum=32'h7FC00000 and rsp_err=1, then go to RESP.
REQ-012 RESP: hold rsp_valid=1 with rsp_id, rsp_sum and rsp_err stable until rsp_valid && rsp_ready; then go to IDLE with rsp_valid=0 in the next cycle.
REQ-013 Only one operation SHALL be outstanding. req_ready SHALL be 0 outside the IDLE grant cycle.
REQ-014 Simultaneous requests: exactly one grant per IDLE visit. A requester with valid held is served within NUM_REQ operations.
REQ-015 req_valid dropping after the grant SHALL NOT affect the operation in flight.
REQ-016 Latency from grant to rsp_valid is not fixed. Minimum is 3 cycles plus the adder time; it depends on window phase and on the adder's align/normalize iterations.
REQ-017 Arithmetic: the controller does no FP arithmetic. Subtraction is only the bit-31 inversion of B. Round-robin pointer wrap is modulo NUM_REQ.

Reset
REQ-018 While reset is asserted: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_err=0, fp_a=0, busy=0, round-robin pointer=NUM_REQ-1, counter=0.
REQ-019 fp_ready_q SHALL reset to 1, so a window already in progress at reset release is never taken as a rise.
REQ-020 Reset mid-operation SHALL abandon the operation with no response. The adder is reset separately and is not touched.

Structure
REQ-021 Package fpadd_pkg SHALL hold the state enum, the canonical NaN constant 32'h7FC00000, and the defaults for NUM_REQ and TIMEOUT.
REQ-022 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and pointer; outputs one-hot grant and index).
REQ-023 Implementation SHALL use one registered FSM with a separate combinational next-state block.

Verification
REQ-024 Single request, requester 2: A=3F800000, B=40000000, sub=0, with the real fpadder -> rsp_id=2, rsp_sum=40400000, rsp_err=0.
REQ-025 Subtraction: A=40400000, B=3F800000, sub=1 -> rsp_sum=40000000.
REQ-026 All four requesters valid at once, held -> grants in order 0,1,2,3, each result correct and tagged with the matching rsp_id.
REQ-027 Request granted while fp_ready is in W2 -> fp_a stays 0 until the next rise; A and B are driven on the cycles the adder loads them (checked with a protocol monitor).
REQ-028 Adder model that never raises fp_ready -> after TIMEOUT cycles rsp_err=1, rsp_sum=7FC00000.
REQ-029 rsp_ready held low for 20 cycles, then reset pulsed during WAIT_SUM -> the response stays stable while stalled, and after reset all outputs are 0 and the next request completes correctly.
